// File: rtl/hb_decim_mc.sv
// hb_decim_mc: multichannel halfband decimate-by-2 filter.
// Each channel keeps its own delay line and decimation phase. One shared
// pre-add MAC walks the symmetric tap pairs and then the centre tap. The
// result is rounded half-up and saturated. Bypass echoes accepted samples
// without decimating, but still advances the delay lines and phases.
module hb_decim_mc #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int NTAPS  = 7,
    parameter int NCH    = 2,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
    parameter logic [NTAPS*COEF_W-1:0] COEFS = {-18'sd2048, 18'sd0, 18'sd18432, 18'sd32768,
                                                18'sd18432, 18'sd0, -18'sd2048}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bypass,
    input  logic [DATA_W-1:0] x_in,
    input  logic [CH_W-1:0]   x_in_ch,
    input  logic              x_in_valid,
    output logic              x_in_ready,
    output logic [DATA_W-1:0] y_out,
    output logic [CH_W-1:0]   y_out_ch,
    output logic              y_out_valid
);

    localparam int NPAIR = (NTAPS + 1) / 4;
    localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int IW    = $clog2(NTAPS);
    localparam int AW    = DATA_W + COEF_W + $clog2(NTAPS) + 1;
    localparam int CTR_I = (NTAPS - 1) / 2;

    // Half an output LSB, and the saturation limits, at accumulator width.
    localparam logic signed [AW-1:0] RND  = {{(AW-COEF_W+2){1'b0}}, 1'b1, {(COEF_W-3){1'b0}}};
    localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_CTR, S_OUT} state_t;

    state_t                              r_state;
    logic                                r_ready;
    logic [PW-1:0]                       r_pair;
    logic [CH_W-1:0]                     r_ch;
    logic signed [AW-1:0]                r_acc;
    logic [DATA_W-1:0]                   r_y;
    logic [CH_W-1:0]                     r_ych;
    logic                                r_yvld;
    logic [NCH-1:0]                      r_phase;
    logic [NCH-1:0][NTAPS-1:0][DATA_W-1:0] r_dl;   // [ch][0] newest .. [ch][NTAPS-1] oldest

    logic                   w_acc, w_legal, w_start;
    logic [CH_W-1:0]        w_wch;
    logic [IW-1:0]          w_ia, w_ib;
    logic [DATA_W-1:0]      w_da, w_db, w_dc;
    logic signed [DATA_W:0] w_pre;
    logic signed [AW-1:0]   w_opnd, w_coefx, w_prod, w_rnd, w_shf;
    logic [COEF_W-1:0]      w_coef;
    logic [DATA_W-1:0]      w_sat;
    logic [COEF_W-1:0]      w_h [NTAPS];

    // Unpack the tap vector; h[0] sits in the most significant slot.
    for (genvar k = 0; k < NTAPS; k++) begin : g_coef
        assign w_h[k] = COEFS[(NTAPS-1-k)*COEF_W +: COEF_W];
    end

    // Out-of-range channels are accepted but must not touch any state.
    assign w_acc   = x_in_valid && r_ready;
    assign w_legal = (int'(x_in_ch) < NCH);
    assign w_wch   = w_legal ? x_in_ch : '0;
    assign w_start = w_acc && w_legal && !bypass && !r_phase[w_wch];

    // Tap pair for the current MAC step plus the centre tap.
    assign w_ia = IW'(2 * int'(r_pair));
    assign w_ib = IW'(NTAPS - 1 - 2 * int'(r_pair));
    assign w_da = r_dl[r_ch][w_ia];
    assign w_db = r_dl[r_ch][w_ib];
    assign w_dc = r_dl[r_ch][IW'(CTR_I)];

    // Symmetric pre-add one bit wider than the data, so it cannot overflow.
    assign w_pre  = {w_da[DATA_W-1], w_da} + {w_db[DATA_W-1], w_db};
    assign w_opnd = (r_state == S_CTR) ? {{(AW-DATA_W){w_dc[DATA_W-1]}}, w_dc}
                                       : {{(AW-DATA_W-1){w_pre[DATA_W]}}, w_pre};
    assign w_coef  = (r_state == S_CTR) ? w_h[IW'(CTR_I)] : w_h[w_ia];
    assign w_coefx = {{(AW-COEF_W){w_coef[COEF_W-1]}}, w_coef};
    assign w_prod  = w_opnd * w_coefx;

    // Round half-up, drop the Q1 fraction, clamp to the output range.
    assign w_rnd = r_acc + RND;
    assign w_shf = w_rnd >>> (COEF_W - 2);
    assign w_sat = (w_shf > MAXV) ? MAXV[DATA_W-1:0] :
                   (w_shf < MINV) ? MINV[DATA_W-1:0] : w_shf[DATA_W-1:0];

    // Control FSM, delay lines, phases, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_pair  <= '0;
            r_ch    <= '0;
            r_acc   <= '0;
            r_y     <= '0;
            r_ych   <= '0;
            r_yvld  <= 1'b0;
            r_phase <= '0;
            r_dl    <= '0;
        end else begin
            r_yvld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= !w_start;
                    if (w_acc && w_legal) begin
                        r_dl[w_wch]    <= {r_dl[w_wch][NTAPS-2:0], x_in};
                        r_phase[w_wch] <= ~r_phase[w_wch];
                        if (bypass) begin
                            r_y    <= x_in;
                            r_ych  <= x_in_ch;
                            r_yvld <= 1'b1;
                        end
                    end
                    if (w_start) begin
                        r_state <= S_MAC;
                        r_ch    <= w_wch;
                        r_pair  <= '0;
                        r_acc   <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (r_pair == PW'(NPAIR - 1)) r_state <= S_CTR;
                    else                          r_pair  <= r_pair + PW'(1);
                end
                S_CTR: begin
                    r_acc   <= r_acc + w_prod;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_y     <= w_sat;
                    r_ych   <= r_ch;
                    r_yvld  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x_in_ready  = r_ready;
    assign y_out       = r_y;
    assign y_out_ch    = r_ych;
    assign y_out_valid = r_yvld;

endmodule
